sha1_block_engine: RTL and testbench

Sequential SHA-1 engine that processes one 512-bit message block per transaction and produces the updated 160-bit chaining value. It holds its own 16-word rolling message schedule. It evaluates ROUNDS_PER_CYCLE compression rounds per clock, so the same RTL covers area-optimised (1 round/cycle) and throughput-optimised builds. It sits between the padding/block-assembly logic and the digest output stage, and uses valid/ready handshakes on both sides.

---
 rtl/sha1_block_engine.sv | 149 ++++++++++++++
 tb/tb_sha1_block_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sha1_block_engine.sv
// SHA-1 compression of one 512-bit block per transaction, ROUNDS_PER_CYCLE rounds per clock.
// Define SHA1_ABORT_EN to add an abort input that cancels an in-flight block.

module sha1_round (
    input  logic [6:0]   t,
    input  logic [159:0] st_in,
    input  logic [511:0] win_in,
    output logic [159:0] st_out,
    output logic [511:0] win_out
);
    logic [31:0] a, b, c, d, e, f, k, temp, w_mix;

    assign {a, b, c, d, e} = st_in;

    always_comb begin
        f = b ^ c ^ d;
        k = 32'hCA62C1D6;
        if (t < 7'd20) begin
            f = (b & c) | (~b & d);
            k = 32'h5A827999;
        end else if (t < 7'd40) begin
            k = 32'h6ED9EBA1;
        end else if (t < 7'd60) begin
            f = (b & c) | (b & d) | (c & d);
            k = 32'h8F1BBCDC;
        end
    end

    // Window word 0 is W_t; the word shifted in at the top is W_{t+16}.
    assign w_mix   = win_in[13*32 +: 32] ^ win_in[8*32 +: 32] ^ win_in[2*32 +: 32] ^ win_in[31:0];
    assign win_out = {w_mix[30:0], w_mix[31], win_in[511:32]};
    assign temp    = {a[26:0], a[31:27]} + f + e + k + win_in[31:0];
    assign st_out  = {temp, a, b[1:0], b[31:2], c, d};
endmodule

module sha1_block_engine #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         use_iv,
    input  logic [159:0] hash_in,
    input  logic [511:0] block_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [159:0] hash_out,
    output logic         busy
`ifdef SHA1_ABORT_EN
    ,
    input  logic         abort
`endif
);
    localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam logic [6:0]   R7 = 7'(ROUNDS_PER_CYCLE);

    if (ROUNDS_PER_CYCLE < 1 || (80 % ROUNDS_PER_CYCLE) != 0) begin : g_bad_rounds
        $error("ROUNDS_PER_CYCLE must divide 80");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [6:0]     cnt_q;
    logic [159:0]   chain_q, st_q, hash_q, sum;
    logic [511:0]   w_q;
    logic           abort_i;

`ifdef SHA1_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    logic [ROUNDS_PER_CYCLE:0][159:0] st_chain;
    logic [ROUNDS_PER_CYCLE:0][511:0] win_chain;

    assign st_chain[0]  = st_q;
    assign win_chain[0] = w_q;

    // Rounds chain combinationally; each one picks f/K from its own round index.
    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_rnd
        sha1_round u_round (
            .t       (cnt_q + 7'(j)),
            .st_in   (st_chain[j]),
            .win_in  (win_chain[j]),
            .st_out  (st_chain[j+1]),
            .win_out (win_chain[j+1])
        );
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < 5; i++)
            sum[32*i +: 32] = chain_q[32*i +: 32] + st_q[32*i +: 32];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_RUN;
            S_RUN: begin
                if (abort_i)                   state_d = S_IDLE;
                else if (cnt_q + R7 == 7'd80)  state_d = S_FINAL;
            end
            S_FINAL: state_d = abort_i ? S_IDLE : S_DONE;
            S_DONE:  if (out_ready || abort_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            chain_q <= '0;
            st_q    <= '0;
            w_q     <= '0;
            hash_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    chain_q <= use_iv ? IV : hash_in;
                    st_q    <= use_iv ? IV : hash_in;
                    cnt_q   <= '0;
                    for (int i = 0; i < 16; i++)
                        w_q[32*i +: 32] <= block_in[511-32*i -: 32];
                end
                S_RUN: begin
                    st_q  <= st_chain[ROUNDS_PER_CYCLE];
                    w_q   <= win_chain[ROUNDS_PER_CYCLE];
                    cnt_q <= cnt_q + R7;
                end
                S_FINAL: if (!abort_i) hash_q <= sum;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_FINAL);
    assign hash_out  = hash_q;
endmodule

// File: tb/tb_sha1_block_engine.sv
// Bench for sha1_block_engine: three builds (R=1,4,80) share stimulus and are checked
// every cycle against a plain SHA-1 model, plus literal digests from the standard vectors.
module tb_sha1_block_engine;
    localparam logic [159:0] IV    = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam logic [511:0] ABC_B = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMP_B = {32'h80000000, 480'h0};
    localparam logic [511:0] B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B2 = {448'h0, 32'h0, 32'h000001c0};
    localparam logic [159:0] ABC_D = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] EMP_D = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] TWO_D = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    logic clk = 0, rst = 1, in_valid = 0, use_iv = 0, out_ready = 1, abort = 0;
    logic [159:0] hash_in = '0;
    logic [511:0] block_in = '0;
    logic [2:0] in_ready_v, out_valid_v, busy_v;
    logic [2:0][159:0] hash_out_v;

    int total = 0, bad = 0, cyc = 0;
    int lat_exp[3] = '{81, 21, 2};
    int seen[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sha1_block_engine #(.ROUNDS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 4 : 80))) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[g]),
            .use_iv(use_iv), .hash_in(hash_in), .block_in(block_in),
            .out_valid(out_valid_v[g]), .out_ready(out_ready),
            .hash_out(hash_out_v[g]), .busy(busy_v[g])
`ifdef SHA1_ABORT_EN
            , .abort(abort)
`endif
        );
    end

    function automatic int rs(int g);
        return g == 0 ? 1 : (g == 1 ? 4 : 80);
    endfunction

    function automatic logic [159:0] sha1_ref(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            tmp  = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {tmp[30:0], tmp[31]};
        end
        {a, b, c, d, e} = h;
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Transaction-level model: one block in flight per build, result due 80/R+1 edges after accept.
    bit [2:0] m_busy = '0;
    int m_done[3];
    logic [159:0] m_exp[3];
    logic [159:0] m_hash[3] = '{default: '0};

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            bit ov_e;
            if (m_busy[g] && cyc == m_done[g]) m_hash[g] = m_exp[g];
            ov_e = m_busy[g] && cyc >= m_done[g];
            chk($sformatf("in_ready[%0d]", g), in_ready_v[g], !m_busy[g] && !rst);
            chk($sformatf("out_valid[%0d]", g), out_valid_v[g], ov_e);
            chk($sformatf("busy[%0d]", g), busy_v[g], m_busy[g] && !ov_e);
            chk($sformatf("hash_out[%0d]", g), hash_out_v[g], m_hash[g]);
            if (rst) begin
                m_busy[g] = 0;
                m_hash[g] = '0;
            end else if (m_busy[g]) begin
                if (ov_e ? (out_ready || abort) : abort) m_busy[g] = 0;
            end else if (in_valid) begin
                m_busy[g] = 1;
                m_exp[g]  = sha1_ref(use_iv ? IV : hash_in, block_in);
                m_done[g] = cyc + 1 + 80 / rs(g) + 1;
            end
        end
    end

    task automatic send(input logic iv, input logic [159:0] h, input logic [511:0] blk);
        int n = 0;
        while (m_busy != 3'b000 && n < 300) begin @(posedge clk); #1; n++; end
        if (m_busy != 3'b000) chk("send_idle_timeout", 1, 0);
        use_iv = iv; hash_in = h; block_in = blk; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_all(input string nm);
        int n = 0;
        seen = '{-1, -1, -1};
        while (m_busy != 3'b000 && n < 300) begin
            @(posedge clk); #1; n++;
            for (int g = 0; g < 3; g++) if (seen[g] < 0 && out_valid_v[g]) seen[g] = n;
        end
        if (m_busy != 3'b000) chk({nm, "_timeout"}, 1, 0);
        for (int g = 0; g < 3; g++) chk($sformatf("%s_latency[%0d]", nm, g), seen[g], lat_exp[g]);
    endtask

    task automatic digest_all(input string nm, input logic [159:0] d);
        for (int g = 0; g < 3; g++) chk($sformatf("%s_digest[%0d]", nm, g), hash_out_v[g], d);
    endtask

    initial begin
        logic [159:0] mid;
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [159:0] mid;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hash", hash_out_v[0], '0);
        chk("reset_out_valid", out_valid_v, 3'b000);
        chk("reset_busy", busy_v, 3'b000);
        chk("reset_in_ready_in_rst", in_ready_v, 3'b000);
        rst = 0;
        #1;
        chk("idle_in_ready", in_ready_v, 3'b111);

        chk("model_abc", sha1_ref(IV, ABC_B), ABC_D);
        chk("model_empty", sha1_ref(IV, EMP_B), EMP_D);
        mid = sha1_ref(IV, B1);
        chk("model_two", sha1_ref(mid, B2), TWO_D);

        send(1, '0, ABC_B);             wait_all("abc");   digest_all("abc", ABC_D);
        send(1, 160'hdead, EMP_B);      wait_all("empty"); digest_all("empty", EMP_D);
        send(1, '0, B1);                wait_all("blk1");  digest_all("blk1", mid);
        send(0, mid, B2);               wait_all("blk2");  digest_all("blk2", TWO_D);

        // Backpressure: result held, new blocks ignored while it waits.
        out_ready = 0;
        send(1, '0, ABC_B);
        for (int n = 0; n < 200 && !out_valid_v[0]; n++) begin @(posedge clk); #1; end
        chk("bp_out_valid_seen", out_valid_v[0], 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 2 == 0);
            block_in = EMP_B;
            chk("bp_hash_stable", hash_out_v[0], ABC_D);
            chk("bp_in_ready_low", in_ready_v, 3'b000);
            chk("bp_out_valid_held", out_valid_v, 3'b111);
        end
        @(posedge clk); #1;
        in_valid = 0;
        out_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", out_valid_v, 3'b000);
        chk("bp_release_in_ready", in_ready_v, 3'b111);
        digest_all("bp", ABC_D);

        // Reset in the middle of the R=1 run.
        send(1, '0, EMP_B);
        repeat (40) @(posedge clk);
        #1;
        chk("mid_busy", busy_v[0], 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        #1;
        chk("rst_out_valid", out_valid_v, 3'b000);
        chk("rst_hash", hash_out_v[0], '0);
        chk("rst_busy", busy_v, 3'b000);
        chk("rst_in_ready", in_ready_v, 3'b111);
        send(1, '0, ABC_B);             wait_all("post_rst"); digest_all("post_rst", ABC_D);

`ifdef SHA1_ABORT_EN
        send(1, '0, EMP_B);
        repeat (10) @(posedge clk);
        #1;
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        chk("abort_out_valid", out_valid_v[0], 0);
        chk("abort_in_ready", in_ready_v[0], 1);
        repeat (90) @(posedge clk);
        #1;
        chk("abort_no_result", hash_out_v[0], ABC_D);
        send(1, '0, B1);                wait_all("post_abort"); digest_all("post_abort", mid);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
